// File: rtl/zap_fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one zap sync FIFO write port between NREQ producers,
// granting bursts of up to MAX_BURST beats and gating every write on the FIFO not-full flag.
module zap_fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ-1:0]         i_last,
    input  logic [NREQ*WIDTH-1:0]   i_data,
    output logic [NREQ-1:0]         o_ack,
    input  logic                    i_fifo_full_n,
    output logic                    o_fifo_wr_en,
    output logic [WIDTH-1:0]        o_fifo_data,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_ff, state_nx;
    logic [NREQ-1:0]   grant_ff, grant_nx;
    logic [IW-1:0]     last_ff, last_nx;
    logic [IW-1:0]     owner_ff, owner_nx;
    logic [BW-1:0]     beat_ff, beat_nx;
    logic              busy_ff, busy_nx;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    int unsigned       cand;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(last_ff) + i) % NREQ;
            if (!win_found && i_req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state and combinational write/ack decode.
    always_comb begin
        state_nx     = state_ff;
        grant_nx     = grant_ff;
        last_nx      = last_ff;
        owner_nx     = owner_ff;
        beat_nx      = beat_ff;
        busy_nx      = busy_ff;
        o_ack        = '0;
        o_fifo_wr_en = 1'b0;
        o_fifo_data  = i_data[32'(owner_ff)*WIDTH +: WIDTH];

        case (state_ff)
            IDLE: begin
                if (win_found) begin
                    state_nx = BURST;
                    grant_nx = NREQ'(1) << win_idx;
                    owner_nx = win_idx;
                    beat_nx  = '0;
                    busy_nx  = 1'b1;
                end
            end
            BURST: begin
                if (!i_req[owner_ff]) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    last_nx  = owner_ff;
                    busy_nx  = 1'b0;
                end else if (i_fifo_full_n) begin
                    o_fifo_wr_en    = 1'b1;
                    o_ack[owner_ff] = 1'b1;
                    beat_nx         = beat_ff + BW'(1);
                    if (i_last[owner_ff] || (beat_ff + BW'(1) == BW'(MAX_BURST))) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        last_nx  = owner_ff;
                        busy_nx  = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A beat in the reset cycle would be lost by the FIFO being reset alongside.
        if (i_reset) begin
            o_ack        = '0;
            o_fifo_wr_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_ff <= IDLE;
            grant_ff <= '0;
            last_ff  <= IW'(NREQ - 1);
            owner_ff <= '0;
            beat_ff  <= '0;
            busy_ff  <= 1'b0;
        end else begin
            state_ff <= state_nx;
            grant_ff <= grant_nx;
            last_ff  <= last_nx;
            owner_ff <= owner_nx;
            beat_ff  <= beat_nx;
            busy_ff  <= busy_nx;
        end
    end

    assign o_grant = grant_ff;
    assign o_busy  = busy_ff;

endmodule

// File: tb/tb_zap_fifo_wr_arbiter.sv
// Directed and randomised checks of zap_fifo_wr_arbiter: grant order, stalls, withdrawal,
// reset mid-burst, and data ordering against a scoreboard and a small FIFO occupancy model.
module tb_zap_fifo_wr_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MAX_BURST = 4;
    localparam int          DEPTH     = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req, last, ack, grant;
    logic [NREQ*WIDTH-1:0] data;
    logic                  full_n, wr_en, busy;
    logic [WIDTH-1:0]      fdata;

    int          vectors = 0;
    int          miscompares = 0;
    bit          rand_ph = 1'b0;
    logic [31:0] exp_q[$];

    zap_fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_last(last), .i_data(data),
        .o_ack(ack), .i_fifo_full_n(full_n), .o_fifo_wr_en(wr_en),
        .o_fifo_data(fdata), .o_grant(grant), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int k, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'hD000_0000 | 32'(k));
    endtask

    // Directed-phase scoreboard: every FIFO write pops the next expected word.
    always @(negedge clk) begin
        if (!rand_ph && !reset && wr_en) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            chk("ack_is_grant", 64'(ack), 64'(grant));
            if (exp_q.size() != 0) chk("fifo_data", 64'(fdata), 64'(exp_q.pop_front()));
        end
    end

    int          seq[NREQ];
    int          left[NREQ];
    bit          active[NREQ];
    int          wt[NREQ];
    int          cnt;
    int          ow;
    logic [NREQ-1:0] prev_grant, prev_req;

    initial begin
        reset = 1'b1; req = '0; last = '0; full_n = 1'b1; data = '0;
        for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = 32'hD000_0000 | 32'(k);
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr", 64'(wr_en), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);

        // Single requester, last on beat 3.
        req = 4'b0001; push_n(0, 3);
        #1 chk("t1_idle_wr", 64'(wr_en), 64'd0);
        cyc(); #1 chk("t1_c1_grant", 64'(grant), 64'b0001); chk("t1_c1_ack", 64'(ack), 64'b0001);
        cyc(); #1 chk("t1_c2_ack", 64'(ack), 64'b0001);
        cyc(); last = 4'b0001; #1 chk("t1_c3_ack", 64'(ack), 64'b0001);
        cyc(); req = '0; last = '0; #1 chk("t1_c4_grant", 64'(grant), 64'd0); chk("t1_c4_busy", 64'(busy), 64'd0);

        // All requesting: rotation 0,1,2,3,0 with full bursts and one-cycle bubbles.
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; req = 4'b1111;
        for (int b = 0; b < 5; b++) push_n(b % 4, 4);
        #1 chk("t2_idle_grant", 64'(grant), 64'd0);
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(); #1;
                chk("t2_grant", 64'(grant), 64'(4'b0001 << (b % 4)));
                chk("t2_ack", 64'(ack), 64'(4'b0001 << (b % 4)));
            end
            cyc();
            if (b == 4) req = '0;
            #1 chk("t2_bubble_wr", 64'(wr_en), 64'd0); chk("t2_bubble_grant", 64'(grant), 64'd0);
        end

        // Owner 2 stalled by a full FIFO; beat count survives the stall.
        req = 4'b0100; push_n(2, 4);
        cyc(); #1 chk("t3_grant", 64'(grant), 64'b0100); chk("t3_beat1", 64'(ack), 64'b0100);
        for (int i = 0; i < 5; i++) begin
            cyc(); full_n = 1'b0;
            #1 chk("t3_stall_wr", 64'(wr_en), 64'd0); chk("t3_stall_ack", 64'(ack), 64'd0);
            chk("t3_stall_grant", 64'(grant), 64'b0100);
        end
        for (int j = 0; j < 3; j++) begin
            cyc(); full_n = 1'b1; #1 chk("t3_resume_ack", 64'(ack), 64'b0100);
        end
        cyc(); req = '0; #1 chk("t3_end_grant", 64'(grant), 64'd0);

        // Owner 1 withdraws after two beats; then 2 beats 3 since search starts after 1.
        push_n(1, 2); push_n(2, 1); push_n(3, 1);
        cyc(); req = 4'b0010; #1 chk("t4_idle", 64'(grant), 64'd0);
        cyc(); req = 4'b1010; #1 chk("t4_grant1", 64'(grant), 64'b0010); chk("t4_ack_b1", 64'(ack), 64'b0010);
        cyc(); #1 chk("t4_ack_b2", 64'(ack), 64'b0010);
        cyc(); req = 4'b1000; #1 chk("t4_drop_wr", 64'(wr_en), 64'd0); chk("t4_drop_ack", 64'(ack), 64'd0);
        cyc(); req = 4'b1100; #1 chk("t4_idle2", 64'(grant), 64'd0);
        cyc(); last = 4'b0100; #1 chk("t4_grant2", 64'(grant), 64'b0100); chk("t4_ack2", 64'(ack), 64'b0100);
        cyc(); req = 4'b1000; last = 4'b1000; #1 chk("t4_idle3", 64'(grant), 64'd0);
        cyc(); #1 chk("t4_grant3", 64'(grant), 64'b1000); chk("t4_ack3", 64'(ack), 64'b1000);
        cyc(); req = '0; last = '0; #1 chk("t4_end", 64'(grant), 64'd0);

        // Reset during beat 2 of owner 1's burst.
        push_n(1, 1); push_n(0, 1);
        cyc(); req = 4'b0010; #1 chk("t5_idle", 64'(grant), 64'd0);
        cyc(); req = 4'b1111; #1 chk("t5_grant1", 64'(grant), 64'b0010); chk("t5_ack_b1", 64'(ack), 64'b0010);
        cyc(); reset = 1'b1; #1 chk("t5_rst_wr", 64'(wr_en), 64'd0); chk("t5_rst_ack", 64'(ack), 64'd0);
        cyc(); reset = 1'b0; #1 chk("t5_post_grant", 64'(grant), 64'd0); chk("t5_post_busy", 64'(busy), 64'd0);
        cyc(); last = 4'b0001; #1 chk("t5_grant0", 64'(grant), 64'b0001); chk("t5_ack0", 64'(ack), 64'b0001);
        cyc(); req = '0; last = '0; #1 chk("t5_end", 64'(grant), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // Random packets and stalls against a FIFO occupancy model.
        rand_ph = 1'b1;
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        cnt = 0; prev_grant = '0; prev_req = '0;
        for (int k = 0; k < NREQ; k++) begin
            seq[k] = 0; left[k] = 0; active[k] = 1'b0; wt[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (wr_en) begin
                chk("r_no_full_wr", 64'(full_n), 64'd1);
                chk("r_ack_onehot", 64'(ack), 64'(grant));
                ow = 0;
                for (int k = 0; k < NREQ; k++) if (ack[k]) ow = k;
                chk("r_data", 64'(fdata), 64'({4'(ow), 28'(seq[ow])}));
                chk("r_last", 64'(last[ow]), 64'(left[ow] == 1));
                seq[ow]++;
                left[ow]--;
                if (left[ow] == 0) active[ow] = 1'b0;
            end else begin
                chk("r_no_ack", 64'(ack), 64'd0);
            end
            if (grant != '0 && prev_grant == '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (grant[k]) wt[k] = 0;
                    else if (prev_req[k] && req[k]) wt[k]++;
                    else wt[k] = 0;
                    chk("r_starve", 64'(wt[k] <= NREQ - 1), 64'd1);
                end
            end
            prev_grant = grant;
            prev_req   = req;
            cnt = cnt + int'(wr_en);
            if (cnt > 0 && $urandom_range(0, 2) == 0) cnt--;
            @(posedge clk);
            #1;
            full_n = (cnt < DEPTH);
            for (int k = 0; k < NREQ; k++) begin
                if (!active[k] && $urandom_range(0, 3) == 0) begin
                    active[k] = 1'b1;
                    left[k]   = int'($urandom_range(1, 6));
                end
                req[k]  = active[k];
                last[k] = active[k] && (left[k] == 1);
                data[k*WIDTH +: WIDTH] = {4'(k), 28'(seq[k])};
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
